// File: rtl/ofm_tx_arb_pkg.sv
// Shared types and constants for the ofm TX offload arbiter: FSM state encoding and AXIS widths.
// Control (txc) and data (txd) beat structs carry tdata/tkeep/tlast through the muxes.
package ofm_tx_arb_pkg;

  localparam int TXC_W  = 32;
  localparam int TXD_W  = 64;
  localparam int TXC_KW = TXC_W / 8;
  localparam int TXD_KW = TXD_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'h0,
    S_CTRL = 2'h1,
    S_DATA = 2'h2
  } state_t;

  typedef struct packed {
    logic [TXC_W-1:0]  tdata;
    logic [TXC_KW-1:0] tkeep;
    logic              tlast;
  } txc_beat_t;

  typedef struct packed {
    logic [TXD_W-1:0]  tdata;
    logic [TXD_KW-1:0] tkeep;
    logic              tlast;
  } txd_beat_t;

endpackage

// File: rtl/ofm_rr_arb2.sv
// Two-way grant selection, purely combinational: round-robin against last_grant, or fixed port-0 priority.
// o_grant is only meaningful while o_vld is high; the caller registers it.
module ofm_rr_arb2 #(
  parameter int C_PRIO_MODE = 0
) (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_vld
);

  assign o_vld = |i_req;

  always_comb begin
    if (C_PRIO_MODE != 0) begin
      o_grant = ~i_req[0];
    end else if (&i_req) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_req[1];
    end
  end

endmodule

// File: rtl/ofm_tx_arb.sv
// Shares the ofm TX offload input (txc then txd per frame) between two MM2S channels, one grant per frame.
// Zero-latency combinational forwarding after a one-cycle arbitration bubble; backpressure passes straight to the granted port.
module ofm_tx_arb
  import ofm_tx_arb_pkg::*;
#(
  parameter int C_PRIO_MODE = 0,
  parameter int C_CNT_W     = 16
) (
  input  logic                mm2s_clk,
  input  logic                mm2s_resetn,
  input  logic [TXC_W-1:0]    s0_txc_tdata,
  input  logic [TXC_KW-1:0]   s0_txc_tkeep,
  input  logic                s0_txc_tvalid,
  input  logic                s0_txc_tlast,
  output logic                s0_txc_tready,
  input  logic [TXD_W-1:0]    s0_txd_tdata,
  input  logic [TXD_KW-1:0]   s0_txd_tkeep,
  input  logic                s0_txd_tvalid,
  input  logic                s0_txd_tlast,
  output logic                s0_txd_tready,
  input  logic [TXC_W-1:0]    s1_txc_tdata,
  input  logic [TXC_KW-1:0]   s1_txc_tkeep,
  input  logic                s1_txc_tvalid,
  input  logic                s1_txc_tlast,
  output logic                s1_txc_tready,
  input  logic [TXD_W-1:0]    s1_txd_tdata,
  input  logic [TXD_KW-1:0]   s1_txd_tkeep,
  input  logic                s1_txd_tvalid,
  input  logic                s1_txd_tlast,
  output logic                s1_txd_tready,
  output logic [TXC_W-1:0]    m_txc_tdata,
  output logic [TXC_KW-1:0]   m_txc_tkeep,
  output logic                m_txc_tvalid,
  output logic                m_txc_tlast,
  input  logic                m_txc_tready,
  output logic [TXD_W-1:0]    m_txd_tdata,
  output logic [TXD_KW-1:0]   m_txd_tkeep,
  output logic                m_txd_tvalid,
  output logic                m_txd_tlast,
  input  logic                m_txd_tready,
  output logic [C_CNT_W-1:0]  s0_frame_cnt,
  output logic [C_CNT_W-1:0]  s1_frame_cnt,
  output logic [3:0]          ofm_tx_arb_dbg
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_grant;
  logic               r_last_grant;
  logic [C_CNT_W-1:0] r_cnt0;
  logic [C_CNT_W-1:0] r_cnt1;

  logic      w_arb_grant;
  logic      w_arb_vld;
  logic      w_grant_load;
  logic      w_frame_done;
  logic      w_ctrl;
  logic      w_data;
  logic      w_txc_vld_sel;
  logic      w_txd_vld_sel;
  logic      w_txc_acc;
  logic      w_txd_acc;
  txc_beat_t w_txc_sel;
  txd_beat_t w_txd_sel;

  ofm_rr_arb2 #(
    .C_PRIO_MODE (C_PRIO_MODE)
  ) u_arb (
    .i_req        ({s1_txc_tvalid, s0_txc_tvalid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_vld        (w_arb_vld)
  );

  assign w_ctrl = (r_state == S_CTRL);
  assign w_data = (r_state == S_DATA);

  // Payload follows the grant even on a closed path; only valid/ready are gated by state.
  assign w_txc_sel     = r_grant ? {s1_txc_tdata, s1_txc_tkeep, s1_txc_tlast}
                                 : {s0_txc_tdata, s0_txc_tkeep, s0_txc_tlast};
  assign w_txd_sel     = r_grant ? {s1_txd_tdata, s1_txd_tkeep, s1_txd_tlast}
                                 : {s0_txd_tdata, s0_txd_tkeep, s0_txd_tlast};
  assign w_txc_vld_sel = r_grant ? s1_txc_tvalid : s0_txc_tvalid;
  assign w_txd_vld_sel = r_grant ? s1_txd_tvalid : s0_txd_tvalid;

  assign m_txc_tdata  = w_txc_sel.tdata;
  assign m_txc_tkeep  = w_txc_sel.tkeep;
  assign m_txc_tlast  = w_txc_sel.tlast;
  assign m_txc_tvalid = w_ctrl & w_txc_vld_sel;
  assign m_txd_tdata  = w_txd_sel.tdata;
  assign m_txd_tkeep  = w_txd_sel.tkeep;
  assign m_txd_tlast  = w_txd_sel.tlast;
  assign m_txd_tvalid = w_data & w_txd_vld_sel;

  assign s0_txc_tready = w_ctrl & ~r_grant & m_txc_tready;
  assign s1_txc_tready = w_ctrl &  r_grant & m_txc_tready;
  assign s0_txd_tready = w_data & ~r_grant & m_txd_tready;
  assign s1_txd_tready = w_data &  r_grant & m_txd_tready;

  assign w_txc_acc = m_txc_tvalid & m_txc_tready;
  assign w_txd_acc = m_txd_tvalid & m_txd_tready;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_load = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_vld) begin
          w_state_nxt  = S_CTRL;
          w_grant_load = 1'b1;
        end
      end
      S_CTRL: begin
        if (w_txc_acc && w_txc_sel.tlast) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_txd_acc && w_txd_sel.tlast) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_load) begin
        r_grant <= w_arb_grant;
      end
      if (w_frame_done) begin
        r_last_grant <= r_grant;
        if (r_grant) begin
          r_cnt1 <= r_cnt1 + C_CNT_W'(1);
        end else begin
          r_cnt0 <= r_cnt0 + C_CNT_W'(1);
        end
      end
    end
  end

  assign s0_frame_cnt   = r_cnt0;
  assign s1_frame_cnt   = r_cnt1;
  assign ofm_tx_arb_dbg = {r_last_grant, r_grant, r_state};

endmodule
